// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and default geometry for the SRAM read-modify-write controller.
package sram_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 6;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RCAP,
    MRD,
    MCAP,
    WR,
    NOP
  } state_t;

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-lane merge: strobed bytes come from new_data, all other bytes from old_data.
module sram_byte_merge #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_rmw_ctrl.sv
// Single-outstanding SRAM controller; partial writes become read, merge, write.
module sram_rmw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic                    sram_csb_o,
  output logic                    sram_web_o,
  output logic                    sram_oeb_o,
  inout  wire  [DATA_WIDTH-1:0]   sram_data_io
);

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    bus_oe;
  logic                    csb_nxt, web_nxt, oeb_nxt, oe_nxt;
  logic                    accept;

  assign req_ready_o  = rst_n && (state == IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign sram_data_io = bus_oe ? wdata_q : 'z;

  sram_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_data (sram_data_io),
    .new_data (wdata_q),
    .strb     (wstrb_q),
    .merged   (merged)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (!req_we_i)             state_nxt = RD;
          else if (&req_wstrb_i)     state_nxt = WR;
          else if (req_wstrb_i == '0) state_nxt = NOP;
          else                       state_nxt = MRD;
        end
      end
      RD:      state_nxt = RCAP;
      RCAP:    state_nxt = IDLE;
      MRD:     state_nxt = MCAP;
      MCAP:    state_nxt = WR;
      WR:      state_nxt = IDLE;
      NOP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes are decoded from the next state so the registered pins line up with state.
  always_comb begin
    csb_nxt = 1'b1;
    web_nxt = 1'b1;
    oeb_nxt = 1'b1;
    oe_nxt  = 1'b0;
    unique case (state_nxt)
      RD, RCAP, MRD, MCAP: begin
        csb_nxt = 1'b0;
        oeb_nxt = 1'b0;
      end
      WR: begin
        csb_nxt = 1'b0;
        web_nxt = 1'b0;
        oe_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sram_csb_o  <= 1'b1;
      sram_web_o  <= 1'b1;
      sram_oeb_o  <= 1'b1;
      bus_oe      <= 1'b0;
      sram_addr_o <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state       <= state_nxt;
      sram_csb_o  <= csb_nxt;
      sram_web_o  <= web_nxt;
      sram_oeb_o  <= oeb_nxt;
      bus_oe      <= oe_nxt;
      rsp_valid_o <= (state == RCAP) || (state == WR) || (state == NOP);
      if (accept) begin
        sram_addr_o <= req_addr_i;
        wdata_q     <= req_wdata_i;
        wstrb_q     <= req_wstrb_i;
      end
      if (state == RCAP) rsp_rdata_o <= sram_data_io;
      if (state == MCAP) wdata_q     <= merged;
    end
  end

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Scoreboard bench for sram_rmw_ctrl paired with a 64x64 synchronous SRAM model.
module tb_sram_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [5:0]  req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wstrb_i;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic [5:0]  sram_addr_o;
  logic        sram_csb_o, sram_web_o, sram_oeb_o;
  wire  [63:0] sram_bus;

  always #5 clk = ~clk;

  sram_rmw_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_wstrb_i  (req_wstrb_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .sram_addr_o  (sram_addr_o),
    .sram_csb_o   (sram_csb_o),
    .sram_web_o   (sram_web_o),
    .sram_oeb_o   (sram_oeb_o),
    .sram_data_io (sram_bus)
  );

  // SRAM model: read data is latched on the strobe edge and driven while oeb is low.
  logic [63:0] mem [64];
  logic [63:0] sram_dout = '0;
  assign sram_bus = (!sram_csb_o && !sram_oeb_o && sram_web_o) ? sram_dout : 'z;
  always @(posedge clk) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) mem[sram_addr_o] <= sram_bus;
      else             sram_dout <= mem[sram_addr_o];
    end
  end

  typedef struct {
    bit          rd;
    logic [63:0] data;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pulses[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   csb_low = 0;
  int   contention = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Monitor: pops one expectation per response pulse; latency counts the acceptance cycle as 1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!sram_csb_o) csb_low++;
      if (rsp_valid_o) begin
        pulses.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got pulse at cycle %0d want none", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk_int({mon_e.nm, "_lat"}, cyc - mon_e.acc + 1, mon_e.lat);
          if (mon_e.rd) chk64({mon_e.nm, "_rdata"}, rsp_rdata_o, mon_e.data);
        end
      end
    end
    if (dut.bus_oe && sram_web_o) contention++;
  end

  task automatic issue(input logic we, input logic [5:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic [63:0] exp_d, input int lat,
                       input string nm, input bit expect_rsp, input bit keep_valid,
                       output int acc);
    int   waited = 0;
    exp_t e;
    acc = -1;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    req_wstrb_i = s;
    while (!req_ready_o && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!req_ready_o) begin
      chk_int({nm, "_ready_timeout"}, 0, 1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (expect_rsp) begin
      e.rd = !we; e.data = exp_d; e.lat = lat; e.acc = acc; e.nm = nm;
      sb.push_back(e);
    end
    if (!keep_valid) req_valid_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk_int({nm, "_drain_timeout"}, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc1, acc2, dummy, n, pcount;
    for (int i = 0; i < 64; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_int("rst_csb", int'(sram_csb_o), 1);
    chk_int("rst_web", int'(sram_web_o), 1);
    chk_int("rst_oeb", int'(sram_oeb_o), 1);
    chk_int("rst_rsp_valid", int'(rsp_valid_o), 0);
    chk64("rst_rdata", rsp_rdata_o, 64'h0);
    chk_int("rst_addr", int'(sram_addr_o), 0);
    chk_int("rst_ready", int'(req_ready_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk_int("ready_after_release", int'(req_ready_o), 1);

    issue(1'b1, 6'd5, 64'h0123456789ABCDEF, 8'hFF, '0, 2, "wr_full", 1'b1, 1'b0, dummy);
    issue(1'b0, 6'd5, '0, '0, 64'h0123456789ABCDEF, 3, "rd5_a", 1'b1, 1'b0, dummy);
    drain("full");

    issue(1'b1, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, '0, 4, "wr_part", 1'b1, 1'b0, dummy);
    issue(1'b0, 6'd5, '0, '0, 64'h01234567FFFFFFFF, 3, "rd5_b", 1'b1, 1'b0, dummy);
    drain("part");

    n = csb_low;
    issue(1'b1, 6'd7, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, '0, 2, "nop", 1'b1, 1'b0, dummy);
    drain("nop");
    chk_int("nop_csb_low_cycles", csb_low - n, 0);
    issue(1'b0, 6'd7, '0, '0, 64'hA5A5000000000007, 3, "rd7", 1'b1, 1'b0, dummy);
    drain("rd7");

    pcount = pulses.size();
    issue(1'b0, 6'd0, '0, '0, 64'hA5A5000000000000, 3, "b2b_rd0", 1'b1, 1'b1, acc1);
    issue(1'b0, 6'd63, '0, '0, 64'hA5A500000000003F, 3, "b2b_rd63", 1'b1, 1'b0, acc2);
    drain("b2b");
    chk_int("b2b_accept_gap", acc2 - acc1, 3);
    if (pulses.size() == pcount + 2) chk_int("b2b_pulse_gap", pulses[pcount+1] - pulses[pcount], 3);
    else chk_int("b2b_pulse_count", pulses.size() - pcount, 2);

    pcount = pulses.size();
    issue(1'b1, 6'd5, 64'h0, 8'hF0, '0, 4, "wr_reset", 1'b0, 1'b0, dummy);
    n = 0;
    while (sram_web_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_int("reached_wr", int'(sram_web_o), 0);
    rst_n = 1'b0;
    #1;
    chk_int("rstwr_bus_released", int'(dut.bus_oe), 0);
    chk_int("rstwr_csb", int'(sram_csb_o), 1);
    chk_int("rstwr_web", int'(sram_web_o), 1);
    chk_int("rstwr_rsp_valid", int'(rsp_valid_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk_int("rstwr_ready_after_release", int'(req_ready_o), 1);
    repeat (3) @(posedge clk);
    #1 chk_int("rstwr_no_pulse", pulses.size() - pcount, 0);
    issue(1'b0, 6'd5, '0, '0, 64'h01234567FFFFFFFF, 3, "rd5_after_rst", 1'b1, 1'b0, dummy);
    drain("after_rst");

    repeat (2) @(posedge clk);
    #1;
    chk_int("bus_contention", contention, 0);
    chk_int("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_rmw_ctrl.md
SRAM_RMW_CTRL -- requirements
Module: sram_rmw_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, SRAM word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, SRAM word-address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-007 SHALL have port req_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i  input  ADDR_WIDTH  word address.
REQ-009 SHALL have port req_wdata_i  input  DATA_WIDTH  write data.
REQ-010 SHALL have port req_wstrb_i  input  DATA_WIDTH/8  byte enables; bit i covers data bits [8i+7:8i].
REQ-011 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse for reads and writes; no back-pressure.
REQ-012 SHALL have port rsp_rdata_o  output  DATA_WIDTH  read data; valid when rsp_valid_o is high after a read.
REQ-013 SHALL have port sram_addr_o  output  ADDR_WIDTH  SRAM address.
REQ-014 SHALL have ports sram_csb_o, sram_web_o, sram_oeb_o  output  1 each  active-low chip select, write enable, output enable.
REQ-015 SHALL have port sram_data_io  inout  DATA_WIDTH  shared tri-state SRAM data bus.

Function
REQ-016 SHALL implement states IDLE, RD, RCAP, MRD, MCAP, WR, NOP; all SRAM-side outputs registered from state.
REQ-017 SHALL assert req_ready_o only in IDLE; one transaction outstanding at most.
REQ-018 SHALL register addr/we/wdata/wstrb at acceptance; input changes after acceptance are ignored.
REQ-019 SHALL route an accepted request: read -> RD; write with wstrb all-ones -> WR; wstrb all-zero -> NOP; other write -> MRD.
REQ-020 SHALL in RD and MRD drive csb=0, web=1, oeb=0 (SRAM read strobe on the next edge).
REQ-021 SHALL in RCAP and MCAP hold csb=0, web=1, oeb=0 and capture sram_data_io on the edge leaving the state.
REQ-022 SHALL in MCAP merge: byte i = wdata byte i when wstrb[i] is 1, else the captured byte; merged word goes to WR.
REQ-023 SHALL in WR drive csb=0, web=0, oeb=1 and drive sram_data_io with the write word; sram_data_io SHALL be high-Z in every other state.
REQ-024 SHALL in IDLE and NOP drive csb=1, web=1, oeb=1, sram_addr_o holding its last value.
REQ-025 SHALL leave RCAP, WR and NOP for IDLE, pulsing rsp_valid_o in the first IDLE cycle.
REQ-026 SHALL give latency from the acceptance edge to the rsp_valid_o pulse of 3 cycles for read, 2 for full write, 2 for NOP, 4 for partial write.
REQ-027 SHALL allow acceptance in the same IDLE cycle that rsp_valid_o pulses (back-to-back, no bubble).
REQ-028 SHALL hold rsp_rdata_o stable from a read response until the next read capture; writes do not change it.
REQ-029 SHALL never drive sram_data_io in a cycle where web=1 (no bus contention).

Reset
REQ-030 SHALL on rst_n low immediately force: state IDLE, csb/web/oeb = 1, sram_data_io high-Z, req_ready_o 0 while in reset, rsp_valid_o 0, rsp_rdata_o 0, sram_addr_o 0.
REQ-031 SHALL drop any in-flight transaction on reset with no response and no partial SRAM write; req_ready_o 1 on the first cycle after release.

Structure
REQ-032 SHALL place the state enum and default width constants in package sram_ctrl_pkg.
REQ-033 SHALL implement the byte-merge in sub-module sram_byte_merge (combinational, parameterised on DATA_WIDTH).

Verification (bench pairs the block with the 64x64 SRAM model)
REQ-034 SHALL verify full write addr 5 data 0x0123456789ABCDEF, strobe 0xFF, then read addr 5 -> rsp pulses at +2 and +3 cycles, rdata 0x0123456789ABCDEF.
REQ-035 SHALL verify partial write addr 5 data 0xFFFF...FF, strobe 0x0F over the above -> read returns 0x01234567FFFFFFFF, write latency 4.
REQ-036 SHALL verify write strobe 0x00 to addr 7 -> csb stays 1 throughout, rsp pulse at +2, contents of addr 7 unchanged.
REQ-037 SHALL verify back-to-back reads of addr 0 and 63 with req_valid_i held high -> second accepted in the first pulse cycle, two pulses 3 cycles apart.
REQ-038 SHALL verify rst_n low during WR of a partial write -> bus released the same cycle, no rsp pulse, target word unchanged.
REQ-039 SHALL verify a bus-contention assertion (no driver of sram_data_io while web=1 and csb=0 and oeb=0) holds for all scenarios.
